// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full_subtractor cell, LSB first.
// Result, borrow and signed overflow load together on entry to DONE.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             amsb, bmsb;
  logic             fd, fb;
  logic             last;

  full_subtractor u_fs (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .diff (fd),
    .bout (fb)
  );

  assign last   = (cnt == CW'(WIDTH - 1));
  // Earlier result bits sit below the bit the cell produces now.
  assign sr_nxt = {fd, sr};
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      sr   <= '0;
      cnt  <= '0;
      br   <= 1'b0;
      amsb <= 1'b0;
      bmsb <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sa   <= a;
            sb   <= b;
            br   <= bin;
            cnt  <= '0;
            amsb <= a[WIDTH-1];
            bmsb <= b[WIDTH-1];
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= fb;
          sr  <= sr_nxt[WIDTH-1:1];
          cnt <= cnt + CW'(1);
          if (last) begin
            diff <= sr_nxt;
            bout <= fb;
            ovf  <= (amsb != bmsb) && (fd != amsb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench: two instances (8 and 4 bits) against an arithmetic model.
// Model tracks accepted starts and expected outputs each cycle.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bout8, ovf8;
  logic [7:0] diff8;
  logic       start4 = 1'b0, bin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, bout4, ovf4;
  logic [3:0] diff4;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .bin(bin8), .busy(busy8), .done(done8), .diff(diff8),
    .bout(bout8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .bin(bin4), .busy(busy4), .done(done4), .diff(diff4),
    .bout(bout4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic ref_sub(input int w, input logic [31:0] x,
                         input logic [31:0] y, input bit bi,
                         output logic [31:0] d, output bit bo,
                         output bit ov);
    longint ux, uy, r, sx, sy, sr, m;
    m  = longint'(1) << w;
    ux = longint'(x);
    uy = longint'(y);
    r  = ux - uy - longint'(bi);
    bo = (r < 0);
    d  = 32'(r & (m - 1));
    sx = x[w-1] ? ux - m : ux;
    sy = y[w-1] ? uy - m : uy;
    sr = sx - sy - longint'(bi);
    ov = (sr < -(m / 2)) || (sr > (m / 2) - 1);
  endtask

  // Behavioural model and per-cycle compare
  int          wd[2] = '{8, 4};
  int          mn[2];
  bit          mact[2];
  logic [31:0] pd[2], hd[2];
  bit          pb[2], po[2], hb[2], ho[2];

  initial begin
    bit          rs;
    bit          st[2], ib[2];
    logic [31:0] ia[2], ibv[2];
    logic [31:0] od;
    logic        obsy, odn, obo, oov;
    bit          eb, ed;
    for (int i = 0; i < 2; i++) begin
      mact[i] = 0; hd[i] = '0; hb[i] = 0; ho[i] = 0; mn[i] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      rs = rst;
      st[0] = start8; ia[0] = 32'(a8); ibv[0] = 32'(b8); ib[0] = bin8;
      st[1] = start4; ia[1] = 32'(a4); ibv[1] = 32'(b4); ib[1] = bin4;
      for (int i = 0; i < 2; i++) begin
        if (rs) begin
          mact[i] = 0; hd[i] = '0; hb[i] = 0; ho[i] = 0;
        end else if (st[i] && !(mact[i] && cyc <= mn[i] + wd[i] + 1)) begin
          mact[i] = 1;
          mn[i] = cyc;
          ref_sub(wd[i], ia[i], ibv[i], ib[i], pd[i], pb[i], po[i]);
        end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (mact[i] && cyc == mn[i] + wd[i]) begin
          hd[i] = pd[i]; hb[i] = pb[i]; ho[i] = po[i];
        end
        eb = mact[i] && cyc >= mn[i] && cyc <= mn[i] + wd[i];
        ed = mact[i] && cyc == mn[i] + wd[i];
        if (i == 0) begin
          od = 32'(diff8); obsy = busy8; odn = done8;
          obo = bout8; oov = ovf8;
        end else begin
          od = 32'(diff4); obsy = busy4; odn = done4;
          obo = bout4; oov = ovf4;
        end
        chk(i == 0 ? "m8_busy" : "m4_busy", 32'(obsy), 32'(eb));
        chk(i == 0 ? "m8_done" : "m4_done", 32'(odn), 32'(ed));
        chk(i == 0 ? "m8_diff" : "m4_diff", od, hd[i]);
        chk(i == 0 ? "m8_bout" : "m4_bout", 32'(obo), 32'(hb[i]));
        chk(i == 0 ? "m8_ovf" : "m4_ovf", 32'(oov), 32'(ho[i]));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb,
                     input logic tbi, input logic [7:0] ed,
                     input bit eb, input bit eo);
    int nb, nd;
    nb = 0;
    nd = 0;
    tick();
    a8 = ta; b8 = tb; bin8 = tbi; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    for (int t = 0; t < 20; t++) begin
      if (busy8) nb++;
      if (done8) begin
        nd++;
        chk("lit_latency", 32'(t), 32'd8);
      end
      tick();
    end
    chk("lit_busy_cycles", 32'(nb), 32'd9);
    chk("lit_done_count", 32'(nd), 32'd1);
    chk("lit_diff", 32'(diff8), 32'(ed));
    chk("lit_bout", 32'(bout8), 32'(eb));
    chk("lit_ovf", 32'(ovf8), 32'(eo));
  endtask

  initial begin
    int nd;
    repeat (3) tick();
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_diff", 32'(diff8), 32'd0);
    rst = 1'b0;
    tick();

    op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    op8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    op8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // start during RUN and DONE is ignored; next IDLE accepts it
    nd = 0;
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int t = 0; t < 24; t++) begin
      if (done8) nd++;
      if (t == 8) chk("bs_done_at_8", 32'(done8), 32'd1);
      if (t == 9) begin
        chk("bs_first_diff", 32'(diff8), 32'h02);
        chk("bs_first_done", 32'(nd), 32'd1);
      end
      if (t == 2 || t == 8) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h11;
      end
      if (t == 3 || t == 10) start8 = 1'b0;
      tick();
    end
    chk("bs_second_diff", 32'(diff8), 32'h99);
    chk("bs_total_done", 32'(nd), 32'd2);

    // reset in the fourth RUN cycle aborts the operation
    nd = 0;
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (t == 4) begin
        rst = 1'b0;
        chk("ra_busy", 32'(busy8), 32'd0);
        chk("ra_done", 32'(done8), 32'd0);
        chk("ra_diff", 32'(diff8), 32'd0);
        chk("ra_bout", 32'(bout8), 32'd0);
        chk("ra_ovf", 32'(ovf8), 32'd0);
      end
      if (t >= 4 && done8) nd++;
      if (t == 3) rst = 1'b1;
      tick();
    end
    chk("ra_no_done", 32'(nd), 32'd0);

    // random traffic with noise on start, operands and reset
    for (int i = 0; i < 1500; i++) begin
      start8 = ($urandom_range(0, 2) == 0);
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    start8 = 1'b0;
    rst = 1'b0;
    repeat (12) tick();

    // exhaustive 4-bit, back to back
    nd = 0;
    for (int c = 0; c < 512; c++) begin
      {a4, b4, bin4} = 9'(c);
      start4 = 1'b1;
      for (int t = 0; t < 6; t++) begin
        tick();
        if (done4) nd++;
      end
    end
    start4 = 1'b0;
    repeat (8) begin
      tick();
      if (done4) nd++;
    end
    chk("ex_done_count", 32'(nd), 32'd512);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
